// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result/NZCV flags; define SEQ_ALU_BARREL_SHIFT_EN for single-cycle shifts
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   k;
    logic             go_shift;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] step_r;
    logic             step_c;

    assign k         = b[SHW-1:0];
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
    logic [SHW:0] inv_k;
    assign inv_k    = (SHW+1)'(WIDTH) - {1'b0, k};
    assign go_shift = 1'b0;
`else
    assign go_shift = (op >= 4'd8) && (op <= 4'd12) && (k != '0);
`endif

    // single-cycle result for every op that does not need the iterative shifter
    always_comb begin
        add_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in & (op == 4'd7)};
        sub_w = {1'b0, a} - {1'b0, b};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            4'd0: alu_r = ~a;
            4'd1: alu_r = ~b;
            4'd2: alu_r = a | b;
            4'd3: alu_r = a & b;
            4'd4: alu_r = a ^ b;
            4'd5, 4'd7: begin
                alu_r = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            4'd6: begin
                alu_r = sub_w[WIDTH-1:0];
                alu_c = ~sub_w[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
`ifdef SEQ_ALU_BARREL_SHIFT_EN
            4'd8:  {alu_c, alu_r} = {1'b0, a} << k;
            4'd9:  {alu_r, alu_c} = {a, 1'b0} >> k;
            4'd10: {alu_r, alu_c} = $signed({a, 1'b0}) >>> k;
            4'd11: begin
                alu_r = (a << k) | (a >> inv_k);
                alu_c = (k != '0) & alu_r[0];
            end
            4'd12: begin
                alu_r = (a >> k) | (a << inv_k);
                alu_c = (k != '0) & alu_r[WIDTH-1];
            end
`else
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12: alu_r = a;
`endif
            4'd13: alu_r = a;
            4'd14: alu_r = b;
            default: alu_r = '0;
        endcase
    end

    // one bit position of the iterative shifter, with the bit shifted out or wrapped
    always_comb begin
        step_r = work;
        step_c = 1'b0;
        case (op_r)
            4'd8:  {step_c, step_r} = {work, 1'b0};
            4'd9:  {step_r, step_c} = {1'b0, work};
            4'd10: {step_r, step_c} = {work[WIDTH-1], work};
            4'd11: {step_c, step_r} = {work[WIDTH-1], work[WIDTH-2:0], work[WIDTH-1]};
            4'd12: {step_c, step_r} = {work[0], work[0], work[WIDTH-1:1]};
            default: ;
        endcase
    end

    // handshake FSM; result and flags only change when an operation completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_r   <= '0;
            work   <= '0;
            cnt    <= '0;
            result <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (go_shift) begin
                        op_r  <= op;
                        work  <= a;
                        cnt   <= k;
                        state <= SHIFT;
                    end else begin
                        result <= alu_r;
                        flag_n <= alu_r[WIDTH-1];
                        flag_z <= alu_r == '0;
                        flag_c <= alu_c;
                        flag_v <= alu_v;
                        state  <= DONE;
                    end
                end
                SHIFT: begin
                    work <= step_r;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result <= step_r;
                        flag_n <= step_r[WIDTH-1];
                        flag_z <= step_r == '0;
                        flag_c <= step_c;
                        flag_v <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
